sequential_divider_32_bit: RTL and testbench

Multi-cycle unsigned restoring divider. It is the inverse arithmetic counterpart of the team's 32-bit ripple adder/subtractor. Each cycle it performs one shift-and-subtract step with a WIDTH+1-bit subtractor, producing quotient and remainder after WIDTH iterations. It sits beside the adder/subtractor in the datapath lab designs and is driven by a simple start/done handshake from a controller or testbench.

---
 rtl/divider_pkg.sv | 14 +
 rtl/div_step.sv | 30 +++
 rtl/sequential_divider_32_bit.sv | 118 +++++++++++
 tb/tb_sequential_divider_32_bit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// State encoding, default width and iteration counter width.
package divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit
// and subtract the divisor using a WIDTH+1-bit subtractor.
module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        r_sh = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
        diff = r_sh - {1'b0, d_i};
        if (!diff[WIDTH]) begin
            r_o = diff;
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end else begin
            r_o = r_sh;
            q_o = {q_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/sequential_divider_32_bit.sv
// Multi-cycle unsigned restoring divider with start/done handshake.
// One quotient bit per cycle; divide-by-zero reports all-ones quotient.
module sequential_divider_32_bit
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_r;
    logic [WIDTH-1:0] step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (step_r),
        .q_o (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    d_d     = divisor;
                    q_d     = dividend;
                    r_d     = '0;
                    zero_d  = (divisor == '0);
                    // zero divisor spends a single RUN cycle before DONE
                    cnt_d   = zero_d ? LAST : '0;
                end
            end
            ST_RUN: begin
                q_d   = step_q;
                r_d   = step_r;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    if (zero_q) begin
                        quot_d = '1;
                        rem_d  = q_q;
                        dbz_d  = 1'b1;
                    end else begin
                        quot_d = step_q;
                        rem_d  = step_r[WIDTH-1:0];
                        dbz_d  = 1'b0;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider_32_bit.sv
// Self-checking bench for sequential_divider_32_bit.
// Expected results are queued at stimulus time and popped on done.
module tb_sequential_divider_32_bit;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int   total;
    int   bad;
    exp_t sb[$];

    sequential_divider_32_bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Drives one request; compares latency, results and the return to IDLE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string nm);
        exp_t e;
        int   n;
        bit   seen;
        int   lat;
        lat = (b == 32'd0) ? 2 : 33;
        sb.push_back(model(a, b));
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1 start = 1'b0;
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s timeout: no done within %0d cycles", nm, n);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        total++;
        if (n !== lat) begin
            bad++;
            $display("FAIL %s latency got=%0d exp=%0d", nm, n, lat);
        end
        total++;
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s %0d/%0d result got q=%h r=%h dz=%b busy=%b exp q=%h r=%h dz=%b busy=1",
                     nm, a, b, quotient, remainder, div_by_zero, busy, e.q, e.r, e.dz);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== e.q || remainder !== e.r) begin
            bad++;
            $display("FAIL %s after_done got done=%b busy=%b q=%h r=%h exp done=0 busy=0 q=%h r=%h",
                     nm, done, busy, quotient, remainder, e.q, e.r);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 0 || done !== 0 || quotient !== 0 || remainder !== 0 || div_by_zero !== 0) begin
            bad++;
            $display("FAIL reset got busy=%b done=%b q=%h r=%h dz=%b exp all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        run_op(32'd100, 32'd7, "basic_100_7");
    endtask

    task automatic test_edges();
        run_op(32'hFFFF_FFFF, 32'd1, "max_by_1");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max_by_max");
        run_op(32'd3, 32'd10, "small_by_big");
        run_op(32'd0, 32'd5, "zero_dividend");
    endtask

    task automatic test_div_zero();
        run_op(32'd5, 32'd0, "div_zero");
        run_op(32'd20, 32'd4, "dz_cleared");
    endtask

    task automatic test_ignore_busy();
        exp_t e;
        int   n;
        bit   seen;
        sb.push_back(model(32'd50, 32'd6));
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd6;
        @(posedge clk);
        #1 start = 1'b0;
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 10) begin
                total++;
                if (quotient !== 32'd5 || remainder !== 32'd0) begin
                    bad++;
                    $display("FAIL hold_prev got q=%h r=%h exp q=5 r=0", quotient, remainder);
                end
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end
            if (n == 11) start = 1'b0;
            if (done) seen = 1;
        end
        total++;
        if (!seen || n !== 33 || sb.size() !== 1) begin
            bad++;
            $display("FAIL ignore_busy done seen=%b n=%0d sb=%0d exp seen=1 n=33 sb=1", seen, n, sb.size());
        end
        e = sb.pop_front();
        total++;
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
            bad++;
            $display("FAIL ignore_busy result got q=%0d r=%0d exp q=%0d r=%0d", quotient, remainder, e.q, e.r);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n;
        bit   seen;
        sb.push_back(model(32'd81, 32'd9));
        sb.push_back(model(32'd200, 32'd7));
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd81;
        divisor  = 32'd9;
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
        end
        e = sb.pop_front();
        total++;
        if (!seen || quotient !== e.q || remainder !== e.r) begin
            bad++;
            $display("FAIL b2b_first got seen=%b q=%0d r=%0d exp q=%0d r=%0d", seen, quotient, remainder, e.q, e.r);
        end
        dividend = 32'd200;
        divisor  = 32'd7;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle_gap got busy=%b exp 0", busy);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept got busy=%b exp 1", busy);
        end
        start = 1'b0;
        n    = 1;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
        end
        e = sb.pop_front();
        total++;
        if (!seen || n !== 33 || quotient !== e.q || remainder !== e.r) begin
            bad++;
            $display("FAIL b2b_second got n=%0d q=%0d r=%0d exp n=33 q=%0d r=%0d", n, quotient, remainder, e.q, e.r);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int  n;
        bit  saw_done;
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd1234567;
        divisor  = 32'd89;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 0 || done !== 0 || quotient !== 0 || remainder !== 0 || div_by_zero !== 0) begin
            bad++;
            $display("FAIL abort_async got busy=%b done=%b q=%h r=%h dz=%b exp all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        saw_done = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        total++;
        if (saw_done) begin
            bad++;
            $display("FAIL abort_no_done got activity=1 exp 0");
        end
        run_op(32'd81, 32'd9, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            case (i % 5)
                0: b = b & 32'h0000_00FF;
                1: b = b & 32'h0000_FFFF;
                2: a = a & 32'h0000_0FFF;
                default: ;
            endcase
            if (i % 97 == 0) b = 32'd0;
            run_op(a, b, "random");
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        test_random();
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
